markov_song_generator: RTL

- Playback counterpart to the Markov learner: consumes a learned Markov chain table and synthesises a new song, one (note, delay) symbol at a time.
- Each step matches the current context against the table and makes a count-weighted pseudo-random choice of the next symbol.
- Symbols stream out over a valid/ready handshake to the downstream song player/formatter.

---
 rtl/markov_song_generator_pkg.sv | 47 ++++
 rtl/markov_song_generator_if.sv | 28 ++
 rtl/markov_lfsr16.sv | 32 +++
 rtl/markov_song_generator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/markov_song_generator_pkg.sv
// Shared constants, table layout and FSM encoding for the Markov song generator.
// Table entry layout (LSB first): count, context symbols 0..SEQUENCE_LEN-2, successor symbol.
// A symbol is {note, delay}, with the delay in the low bits.
// Also provides the 16-bit Galois LFSR step used by the generator's PRNG.
package markov_song_generator_pkg;

  localparam int unsigned NOTE_BIT_LEN     = 6;
  localparam int unsigned DELAY_BIT_LEN    = 4;
  localparam int unsigned SEQUENCE_LEN     = 2;
  localparam int unsigned SEQ_CNT_BIT_LEN  = 8;
  localparam int unsigned MARKOV_CHAIN_LEN = 16;
  localparam int unsigned SONG_OUTPUT_LEN  = 32;

  localparam int unsigned SYM_BIT_LEN   = NOTE_BIT_LEN + DELAY_BIT_LEN;
  localparam int unsigned CTX_BIT_LEN   = (SEQUENCE_LEN - 1) * SYM_BIT_LEN;
  localparam int unsigned ENTRY_BIT_LEN = SEQUENCE_LEN * SYM_BIT_LEN + SEQ_CNT_BIT_LEN;
  localparam int unsigned TABLE_BIT_LEN = ENTRY_BIT_LEN * MARKOV_CHAIN_LEN;

  // Field offsets inside one table entry.
  localparam int unsigned CNT_OFFSET  = 0;
  localparam int unsigned CTX_OFFSET  = SEQ_CNT_BIT_LEN;
  localparam int unsigned SUCC_OFFSET = SEQ_CNT_BIT_LEN + CTX_BIT_LEN;

  // Sum of all counts fits without overflow.
  localparam int unsigned TOTAL_BIT_LEN    = SEQ_CNT_BIT_LEN + $clog2(MARKOV_CHAIN_LEN);
  localparam int unsigned PROD_BIT_LEN     = 16 + TOTAL_BIT_LEN;
  localparam int unsigned IDX_BIT_LEN      = $clog2(MARKOV_CHAIN_LEN);
  localparam int unsigned SONG_CNT_BIT_LEN = $clog2(SONG_OUTPUT_LEN + 1);

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDraw,
    StSelect,
    StEmit,
    StFinish
  } gen_state_e;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/markov_song_generator_if.sv
// Symbol stream between the generator and the downstream song player.
//   note_out, delay_out : generated symbol, stable while out_valid && !out_ready
//   out_valid           : symbol available
//   out_ready           : downstream accepts
// master = generator side, slave = consumer side.
interface markov_song_generator_if;
  import markov_song_generator_pkg::*;

  logic [NOTE_BIT_LEN-1:0]  note_out;
  logic [DELAY_BIT_LEN-1:0] delay_out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output note_out,
    output delay_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  note_out,
    input  delay_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/markov_lfsr16.sv
// 16-bit Galois LFSR (taps 16'hB400) used as the generator's PRNG.
//   clk, reset   : clock, asynchronous active-low reset (resets to 16'hACE1)
//   load_i       : load load_value_i (has priority over enable_i)
//   load_value_i : value to load
//   enable_i     : advance one step
//   value_o      : current LFSR state
module markov_lfsr16
  import markov_song_generator_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  input  logic        enable_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_RESET;
    end else if (load_i) begin
      lfsr_q <= load_value_i;
    end else if (enable_i) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/markov_song_generator.sv
// Markov chain song generator: walks a learned chain table and emits a new song of
// SONG_OUTPUT_LEN (note, delay) symbols, each picked by a count-weighted pseudo-random draw
// among the table entries whose context matches the current context.
//   clk, reset    : clock, asynchronous active-low reset
//   start         : one-cycle pulse, starts a run from IDLE or FINISH
//   seed_context  : initial context (oldest symbol in LSBs), sampled on start
//   lfsr_seed     : PRNG seed (0 selects 16'hACE1), sampled on start
//   markov        : chain table, held stable for the whole run
//   out_if        : symbol stream (master side)
//   done          : high in FINISH until the next start
//   dead_end      : run ended because no entry matched the context
// Optional build macro MARKOV_GEN_DEADEND_RESEED_EN: on a dead end, restart from the seed
// context instead of finishing; only a seed context with no match ends the run.
module markov_song_generator
  import markov_song_generator_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CTX_BIT_LEN-1:0]    seed_context,
  input  logic [15:0]               lfsr_seed,
  input  logic [TABLE_BIT_LEN-1:0]  markov,
  markov_song_generator_if.master   out_if,
  output logic                      done,
  output logic                      dead_end
);

  gen_state_e                  state_q;
  logic [IDX_BIT_LEN-1:0]      idx_q;
  logic [TOTAL_BIT_LEN-1:0]    total_q;
  logic [TOTAL_BIT_LEN-1:0]    acc_q;
  logic [TOTAL_BIT_LEN-1:0]    r_q;
  logic [CTX_BIT_LEN-1:0]      context_q;
  logic [SONG_CNT_BIT_LEN-1:0] song_cnt_q;
  logic [NOTE_BIT_LEN-1:0]     note_q;
  logic [DELAY_BIT_LEN-1:0]    delay_q;
  logic                        valid_q;
  logic                        done_q;
  logic                        dead_end_q;
`ifdef MARKOV_GEN_DEADEND_RESEED_EN
  logic [CTX_BIT_LEN-1:0]      seed_ctx_q;
  // Current context is the seed context (no symbol emitted since it was loaded).
  logic                        at_seed_q;
`endif

  // Entry currently addressed by the scan/select pointer.
  logic [ENTRY_BIT_LEN-1:0]   entry;
  logic [SEQ_CNT_BIT_LEN-1:0] entry_cnt;
  logic [CTX_BIT_LEN-1:0]     entry_ctx;
  logic [SYM_BIT_LEN-1:0]     entry_succ;
  logic                       entry_hit;
  logic [TOTAL_BIT_LEN-1:0]   entry_weight;
  logic [TOTAL_BIT_LEN-1:0]   total_sum;
  logic [TOTAL_BIT_LEN-1:0]   acc_sum;
  logic                       last_idx;
  logic [IDX_BIT_LEN-1:0]     idx_next;
  logic [TOTAL_BIT_LEN-1:0]   draw_r;
  logic [CTX_BIT_LEN-1:0]     context_shift;
  logic                       start_load;
  logic                       last_song_sym;
  logic [15:0]                lfsr_value;
  logic [15:0]                lfsr_next;
  logic [15:0]                lfsr_load_value;

  assign entry        = markov[idx_q * ENTRY_BIT_LEN +: ENTRY_BIT_LEN];
  assign entry_cnt    = entry[CNT_OFFSET +: SEQ_CNT_BIT_LEN];
  assign entry_ctx    = entry[CTX_OFFSET +: CTX_BIT_LEN];
  assign entry_succ   = entry[SUCC_OFFSET +: SYM_BIT_LEN];
  assign entry_hit    = (entry_cnt != '0) && (entry_ctx == context_q);
  assign entry_weight = entry_hit ? TOTAL_BIT_LEN'(entry_cnt) : '0;
  assign total_sum    = total_q + entry_weight;
  assign acc_sum      = acc_q + entry_weight;
  assign last_idx     = (idx_q == IDX_BIT_LEN'(MARKOV_CHAIN_LEN - 1));
  assign idx_next     = last_idx ? '0 : idx_q + IDX_BIT_LEN'(1);

  // Scale the fresh 16-bit draw into [0, total).
  assign lfsr_next = lfsr_step(lfsr_value);
  assign draw_r    = TOTAL_BIT_LEN'((PROD_BIT_LEN'(lfsr_next) * PROD_BIT_LEN'(total_q)) >> 16);

  // Drop the oldest symbol (LSBs) and append the emitted one at the top.
  assign context_shift = CTX_BIT_LEN'({note_q, delay_q, context_q} >> SYM_BIT_LEN);

  assign start_load      = start && ((state_q == StIdle) || (state_q == StFinish));
  assign lfsr_load_value = (lfsr_seed == 16'h0000) ? LFSR_RESET : lfsr_seed;
  assign last_song_sym   = (song_cnt_q == SONG_CNT_BIT_LEN'(SONG_OUTPUT_LEN - 1));

  markov_lfsr16 u_lfsr (
    .clk          (clk),
    .reset        (reset),
    .load_i       (start_load),
    .load_value_i (lfsr_load_value),
    .enable_i     (state_q == StDraw),
    .value_o      (lfsr_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      total_q    <= '0;
      acc_q      <= '0;
      r_q        <= '0;
      context_q  <= '0;
      song_cnt_q <= '0;
      note_q     <= '0;
      delay_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      dead_end_q <= 1'b0;
`ifdef MARKOV_GEN_DEADEND_RESEED_EN
      seed_ctx_q <= '0;
      at_seed_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle, StFinish: begin
          if (start_load) begin
            context_q  <= seed_context;
            done_q     <= 1'b0;
            dead_end_q <= 1'b0;
            song_cnt_q <= '0;
            idx_q      <= '0;
            total_q    <= '0;
`ifdef MARKOV_GEN_DEADEND_RESEED_EN
            seed_ctx_q <= seed_context;
            at_seed_q  <= 1'b1;
`endif
            state_q    <= StScan;
          end
        end

        StScan: begin
          total_q <= total_sum;
          idx_q   <= idx_next;
          if (last_idx) begin
            if (total_sum == '0) begin
`ifdef MARKOV_GEN_DEADEND_RESEED_EN
              if (at_seed_q) begin
                done_q     <= 1'b1;
                dead_end_q <= 1'b1;
                state_q    <= StFinish;
              end else begin
                context_q <= seed_ctx_q;
                at_seed_q <= 1'b1;
                total_q   <= '0;
                state_q   <= StScan;
              end
`else
              done_q     <= 1'b1;
              dead_end_q <= 1'b1;
              state_q    <= StFinish;
`endif
            end else begin
              state_q <= StDraw;
            end
          end
        end

        StDraw: begin
          r_q     <= draw_r;
          acc_q   <= '0;
          idx_q   <= '0;
          state_q <= StSelect;
        end

        StSelect: begin
          if (entry_hit && (acc_sum > r_q)) begin
            note_q  <= entry_succ[SYM_BIT_LEN-1:DELAY_BIT_LEN];
            delay_q <= entry_succ[DELAY_BIT_LEN-1:0];
            valid_q <= 1'b1;
            state_q <= StEmit;
          end else begin
            acc_q <= acc_sum;
            idx_q <= idx_next;
            // Only reachable if the table changed mid-run.
            if (last_idx) begin
              done_q     <= 1'b1;
              dead_end_q <= 1'b1;
              state_q    <= StFinish;
            end
          end
        end

        StEmit: begin
          if (out_if.out_ready) begin
            valid_q    <= 1'b0;
            context_q  <= context_shift;
            song_cnt_q <= song_cnt_q + SONG_CNT_BIT_LEN'(1);
            idx_q      <= '0;
            total_q    <= '0;
`ifdef MARKOV_GEN_DEADEND_RESEED_EN
            at_seed_q  <= 1'b0;
`endif
            if (last_song_sym) begin
              done_q  <= 1'b1;
              state_q <= StFinish;
            end else begin
              state_q <= StScan;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_if.note_out  = note_q;
  assign out_if.delay_out = delay_q;
  assign out_if.out_valid = valid_q;
  assign done             = done_q;
  assign dead_end         = dead_end_q;

endmodule
